carrier_loop_ctrl: RTL and testbench

CARRIER_LOOP_CTRL -- requirements
Module: carrier_loop_ctrl

---
 rtl/qam_ctrl_pkg.sv | 23 ++
 rtl/pd_mag_cmp.sv | 23 ++
 rtl/carrier_loop_ctrl.sv | 176 +++++++++++++++++
 tb/tb_carrier_loop_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/qam_ctrl_pkg.sv
// Shared encodings and widths for the QAM receiver control blocks.
package qam_ctrl_pkg;

  localparam int unsigned PD_W    = 34;
  localparam int unsigned GAIN_W  = 2;
  localparam int unsigned RETRY_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQ     = 2'd1,
    ST_TRACK   = 2'd2,
    ST_RESTART = 2'd3
  } ctrl_state_e;

  localparam logic [GAIN_W-1:0] GAIN_OFF    = 2'd0;
  localparam logic [GAIN_W-1:0] GAIN_WIDE   = 2'd1;
  localparam logic [GAIN_W-1:0] GAIN_NARROW = 2'd2;

  // Most negative pd and the largest representable magnitude it saturates to.
  localparam logic [PD_W-1:0] PD_MIN     = {1'b1, {(PD_W-1){1'b0}}};
  localparam logic [PD_W-1:0] PD_MAG_MAX = {1'b0, {(PD_W-1){1'b1}}};

endpackage

// File: rtl/pd_mag_cmp.sv
// Saturating |pd| against the lock threshold; good_c is purely combinational.
module pd_mag_cmp
  import qam_ctrl_pkg::*;
(
  input  logic signed [PD_W-1:0] pd,
  input  logic        [PD_W-1:0] thr,
  output logic                   good_c
);

  logic [PD_W-1:0] pd_u;
  logic [PD_W-1:0] mag;

  always_comb begin
    pd_u = pd;
    mag  = pd_u;
    if (pd_u[PD_W-1]) begin
      mag = (pd_u == PD_MIN) ? PD_MAG_MAX : ~pd_u + PD_W'(1);
    end
  end

  assign good_c = (mag < thr);

endmodule

// File: rtl/carrier_loop_ctrl.sv
// Carrier recovery loop supervisor: symbol strobe, acquire/track/restart FSM,
// loop-filter gain selection and lock indication.
module carrier_loop_ctrl
  import qam_ctrl_pkg::*;
#(
  parameter int unsigned     SPS         = 8,
  parameter logic [PD_W-1:0] LOCK_THR    = 34'd4000000,
  parameter int unsigned     LOCK_CNT    = 64,
  parameter int unsigned     UNLOCK_CNT  = 16,
  parameter int unsigned     ACQ_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic signed [PD_W-1:0] pd,
  output logic                   bitsync,
  output logic [GAIN_W-1:0]      gain_sel,
  output logic                   loop_clr,
  output logic                   lock,
  output logic [1:0]             state,
  output logic [RETRY_W-1:0]     retries
);

  localparam int unsigned SYM_W  = $clog2(SPS);
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned ACQ_W  = $clog2(ACQ_TIMEOUT + 1);

  ctrl_state_e          state_q, state_d;
  logic [SYM_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic                 bitsync_q, bitsync_d;
  logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d, good_n;
  logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d, bad_n;
  logic [ACQ_W-1:0]     acq_cnt_q, acq_cnt_d, acq_n;
  logic [SYM_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [RETRY_W-1:0]   retries_q, retries_d;
  logic [GAIN_W-1:0]    gain_sel_q, gain_sel_d;
  logic                 loop_clr_q, loop_clr_d;
  logic                 lock_q, lock_d;
  logic                 sym_good_c;

  pd_mag_cmp u_pd_mag_cmp (
    .pd     (pd),
    .thr    (LOCK_THR),
    .good_c (sym_good_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= '0;
      bitsync_q  <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      acq_cnt_q  <= '0;
      rst_cnt_q  <= '0;
      retries_q  <= '0;
      gain_sel_q <= GAIN_OFF;
      loop_clr_q <= 1'b1;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      bitsync_q  <= bitsync_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      acq_cnt_q  <= acq_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      retries_q  <= retries_d;
      gain_sel_q <= gain_sel_d;
      loop_clr_q <= loop_clr_d;
      lock_q     <= lock_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q + SYM_W'(1);
    bitsync_d  = (sym_cnt_q == '0);
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    acq_cnt_d  = acq_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    retries_d  = retries_q;
    gain_sel_d = GAIN_OFF;
    loop_clr_d = 1'b1;
    lock_d     = 1'b0;
    good_n     = sym_good_c ? good_cnt_q + GOOD_W'(1) : '0;
    bad_n      = sym_good_c ? '0 : bad_cnt_q + BAD_W'(1);
    acq_n      = acq_cnt_q + ACQ_W'(1);

    case (state_q)
      ST_IDLE: begin
        good_cnt_d = '0;
        bad_cnt_d  = '0;
        acq_cnt_d  = '0;
        rst_cnt_d  = '0;
        retries_d  = '0;
        if (enable) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        // Lock is checked before the timeout so a tie goes to TRACK.
        if (bitsync_q) begin
          good_cnt_d = good_n;
          acq_cnt_d  = acq_n;
          if (good_n == GOOD_W'(LOCK_CNT)) begin
            state_d    = ST_TRACK;
            good_cnt_d = '0;
            acq_cnt_d  = '0;
            bad_cnt_d  = '0;
          end else if (acq_n == ACQ_W'(ACQ_TIMEOUT)) begin
            state_d    = ST_RESTART;
            good_cnt_d = '0;
            acq_cnt_d  = '0;
            bad_cnt_d  = '0;
            rst_cnt_d  = '0;
            if (retries_q != '1) retries_d = retries_q + RETRY_W'(1);
          end
        end
      end
      ST_TRACK: begin
        if (bitsync_q) begin
          bad_cnt_d = bad_n;
          if (bad_n == BAD_W'(UNLOCK_CNT)) begin
            state_d   = ST_RESTART;
            bad_cnt_d = '0;
            rst_cnt_d = '0;
          end
        end
      end
      ST_RESTART: begin
        if (rst_cnt_q == SYM_W'(SPS - 1)) begin
          state_d    = ST_ACQ;
          rst_cnt_d  = '0;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          acq_cnt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + SYM_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d    = ST_IDLE;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      acq_cnt_d  = '0;
      rst_cnt_d  = '0;
      retries_d  = '0;
    end

    // Outputs are registered from the next state so they change with it.
    case (state_d)
      ST_ACQ: begin
        gain_sel_d = GAIN_WIDE;
        loop_clr_d = 1'b0;
      end
      ST_TRACK: begin
        gain_sel_d = GAIN_NARROW;
        loop_clr_d = 1'b0;
        lock_d     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bitsync  = bitsync_q;
  assign gain_sel = gain_sel_q;
  assign loop_clr = loop_clr_q;
  assign lock     = lock_q;
  assign state    = state_q;
  assign retries  = retries_q;

endmodule

// File: tb/tb_carrier_loop_ctrl.sv
// Scoreboard bench for carrier_loop_ctrl: stimulus queues cycle-stamped expected
// output snapshots, a negedge monitor pops and compares them.
module tb_carrier_loop_ctrl;

  localparam logic signed [33:0] PD_NEG_MAX = 34'sh200000000;
  localparam logic signed [33:0] PD_GOOD    = 34'sd1000;
  localparam logic signed [33:0] PD_BAD     = 34'sd4000000;

  typedef struct {
    int          due;
    int          id;
    string       name;
    logic [14:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic flush = 1'b0;
  chk_t sb[$];
  chk_t mon_c;
  logic [14:0] mon_act;
  logic tog = 1'b0;

  logic               en_a = 1'b0, en_s = 1'b0, en_t = 1'b0;
  logic signed [33:0] pd_a = '0, pd_s = '0, pd_t = '0;
  logic               bs_a, bs_s, bs_t;
  logic [1:0]         gs_a, gs_s, gs_t;
  logic               clr_a, clr_s, clr_t;
  logic               lk_a, lk_s, lk_t;
  logic [1:0]         st_a, st_s, st_t;
  logic [7:0]         rt_a, rt_s, rt_t;

  logic signed [33:0] sim_v1 [8];
  logic signed [33:0] sim_v2 [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carrier_loop_ctrl u_dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .pd(pd_a), .bitsync(bs_a), .gain_sel(gs_a),
    .loop_clr(clr_a), .lock(lk_a), .state(st_a), .retries(rt_a)
  );

  carrier_loop_ctrl #(.LOCK_CNT(8), .ACQ_TIMEOUT(8)) u_dut_s (
    .clk(clk), .rst(rst), .enable(en_s), .pd(pd_s), .bitsync(bs_s), .gain_sel(gs_s),
    .loop_clr(clr_s), .lock(lk_s), .state(st_s), .retries(rt_s)
  );

  carrier_loop_ctrl #(.SPS(4), .ACQ_TIMEOUT(32)) u_dut_t (
    .clk(clk), .rst(rst), .enable(en_t), .pd(pd_t), .bitsync(bs_t), .gain_sel(gs_t),
    .loop_clr(clr_t), .lock(lk_t), .state(st_t), .retries(rt_t)
  );

  function automatic logic [14:0] act_snap(input int id);
    case (id)
      0:       return {bs_a, st_a, gs_a, clr_a, lk_a, rt_a};
      1:       return {bs_s, st_s, gs_s, clr_s, lk_s, rt_s};
      default: return {bs_t, st_t, gs_t, clr_t, lk_t, rt_t};
    endcase
  endfunction

  function automatic string fmt(input logic [14:0] s);
    return $sformatf("bs=%0d st=%0d gs=%0d clr=%0d lock=%0d ret=%0d",
                     s[14], s[13:12], s[11:10], s[9], s[8], s[7:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  // Queue an expected snapshot for one DUT at an absolute cycle, kept sorted by due.
  task automatic expect_at(input int id, input int due, input string nm, input int bs,
                           input int st, input int gs, input int clr, input int lk, input int rt);
    chk_t e;
    int   i;
    e.due  = due;
    e.id   = id;
    e.name = nm;
    e.exp  = {1'(bs), 2'(st), 2'(gs), 1'(clr), 1'(lk), 8'(rt)};
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && (sb[0].due <= cyc || flush)) begin
      mon_c   = sb.pop_front();
      mon_act = act_snap(mon_c.id);
      n_vec++;
      if (mon_c.due != cyc) begin
        n_miss++;
        $display("FAIL %s dut%0d: due cyc %0d not checked (now %0d), want %s",
                 mon_c.name, mon_c.id, mon_c.due, cyc, fmt(mon_c.exp));
      end else if (mon_act !== mon_c.exp) begin
        n_miss++;
        $display("FAIL %s dut%0d cyc %0d: got %s, want %s",
                 mon_c.name, mon_c.id, cyc, fmt(mon_act), fmt(mon_c.exp));
      end
    end
  end

  initial begin
    sim_v1 = '{34'sd3999999, -34'sd3999999, 34'sd0, 34'sd3999999,
               -34'sd3999999, 34'sd1000, -34'sd1, -34'sd4000000};
    sim_v2 = '{34'sd3999999, 34'sd0, -34'sd3999999, 34'sd1,
               -34'sd1, 34'sd3999999, -34'sd3999999, 34'sd0};

    // Reset: all DUTs at reset values, then free-running strobe with enable low.
    repeat (3) tick();
    for (int id = 0; id < 3; id++) expect_at(id, 3, "reset", 0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) expect_at(0, 4 + k, "rst_period8", (k % 8 == 0), 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++)  expect_at(2, 4 + k, "rst_period4", (k % 4 == 0), 0, 0, 1, 0, 0);

    // Acquisition on constant good pd: 64th sample at 524, TRACK in 525.
    tick_to(19);
    en_a = 1'b1;
    pd_a = PD_GOOD;
    expect_at(0, 19,  "acq_idle",  0, 0, 0, 1, 0, 0);
    expect_at(0, 20,  "acq_enter", 1, 1, 1, 0, 0, 0);
    expect_at(0, 524, "acq_last",  1, 1, 1, 0, 0, 0);
    expect_at(0, 525, "lock",      0, 2, 2, 0, 1, 0);

    // Unlock: 10 bad, 1 good, 16 bad (most negative pd) -> RESTART in 741.
    tick_to(525);
    pd_a = PD_NEG_MAX;
    expect_at(0, 653, "unlock_hold", 0, 2, 2, 0, 1, 0);
    expect_at(0, 700, "unlock_mid",  1, 2, 2, 0, 1, 0);
    expect_at(0, 740, "unlock_last", 1, 2, 2, 0, 1, 0);
    expect_at(0, 741, "restart",     0, 3, 0, 1, 0, 0);
    expect_at(0, 748, "restart_end", 1, 3, 0, 1, 0, 0);
    expect_at(0, 749, "reacq",       0, 1, 1, 0, 0, 0);
    tick_to(612);
    pd_a = 34'sd12345;
    tick_to(613);
    pd_a = PD_NEG_MAX;

    // Relock, then drop enable mid-TRACK.
    tick_to(749);
    pd_a = PD_GOOD;
    expect_at(0, 1260, "relock_last", 1, 1, 1, 0, 0, 0);
    expect_at(0, 1261, "relock",      0, 2, 2, 0, 1, 0);
    tick_to(1270);
    en_a = 1'b0;
    expect_at(0, 1270, "en_drop_pre", 0, 2, 2, 0, 1, 0);
    expect_at(0, 1271, "en_drop",     0, 0, 0, 1, 0, 0);

    // Threshold boundary then simultaneous lock/timeout (LOCK_CNT = ACQ_TIMEOUT = 8).
    tick_to(1275);
    en_s = 1'b1;
    pd_s = sim_v1[0];
    expect_at(1, 1276, "sim_acq",      1, 1, 1, 0, 0, 0);
    expect_at(1, 1332, "sim_bad_last", 1, 1, 1, 0, 0, 0);
    expect_at(1, 1333, "thr_timeout",  0, 3, 0, 1, 0, 1);
    expect_at(1, 1341, "sim_reacq",    0, 1, 1, 0, 0, 1);
    expect_at(1, 1404, "sim_last",     1, 1, 1, 0, 0, 1);
    expect_at(1, 1405, "sim_lock",     0, 2, 2, 0, 1, 1);
    expect_at(1, 1410, "sim_en_pre",   0, 2, 2, 0, 1, 1);
    expect_at(1, 1411, "sim_en_drop",  0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 8; j++) begin
      tick_to(1276 + 8 * j);
      pd_s = sim_v1[j];
    end
    for (int j = 0; j < 8; j++) begin
      tick_to(1348 + 8 * j);
      pd_s = sim_v2[j];
    end
    tick_to(1410);
    en_s = 1'b0;

    // Timeouts every 132 cycles (SPS 4, 32 symbols) with retries saturating at 255.
    tick_to(1415);
    en_t = 1'b1;
    pd_t = PD_GOOD;
    for (int k = 1; k <= 257; k++) begin
      expect_at(2, 1540 + 132 * (k - 1), "to_pre",  1, 1, 1, 0, 0, (k - 1 > 255) ? 255 : k - 1);
      expect_at(2, 1541 + 132 * (k - 1), "timeout", 0, 3, 0, 1, 0, (k > 255) ? 255 : k);
    end
    expect_at(2, 35334, "to_en_pre",  0, 3, 0, 1, 0, 255);
    expect_at(2, 35335, "to_en_drop", 0, 0, 0, 1, 0, 0);
    while (cyc < 35334) begin
      tick();
      if (cyc % 4 == 0) begin
        pd_t = tog ? PD_BAD : PD_GOOD;
        tog  = ~tog;
      end
    end
    en_t = 1'b0;

    // Asynchronous reset mid-ACQ takes effect before the next clock edge.
    tick_to(35336);
    en_a = 1'b1;
    pd_a = PD_GOOD;
    tick_to(35345);
    expect_at(0, 35345, "pre_async", 0, 1, 1, 0, 0, 0);
    tick_to(35346);
    rst = 1'b1;
    expect_at(0, 35346, "async_rst", 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    flush = 1'b1;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
